// File: rtl/mem_arbiter.sv
// Three-client arbiter for the single-port system RAM: buffered CPU/GPU writes
// take the slot first, then reads are granted round-robin CPU -> GPU -> scan.
module mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_mem_read,
  input  logic [ADDR_W-1:0] cpu_mem_read_addr,
  output logic [DATA_W-1:0] cpu_mem_read_data,
  output logic              cpu_mem_read_ack,
  input  logic              cpu_mem_write,
  input  logic [ADDR_W-1:0] cpu_mem_write_addr,
  input  logic [DATA_W-1:0] cpu_mem_write_data,
  input  logic              gpu_mem_read,
  input  logic [ADDR_W-1:0] gpu_mem_read_addr,
  output logic [DATA_W-1:0] gpu_mem_read_data,
  output logic              gpu_mem_read_ack,
  input  logic              gpu_mem_write,
  input  logic [ADDR_W-1:0] gpu_mem_write_addr,
  input  logic [DATA_W-1:0] gpu_mem_write_data,
  input  logic              scan_mem_read,
  input  logic [ADDR_W-1:0] scan_mem_read_addr,
  output logic [DATA_W-1:0] scan_mem_read_data,
  output logic              scan_mem_read_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wr_overflow
);

  typedef enum logic [1:0] {SLOT_IDLE, SLOT_CPU_WR, SLOT_GPU_WR, SLOT_READ} slot_e;
  typedef enum logic [1:0] {RR_CPU, RR_GPU, RR_SCAN} rr_e;

  logic              cpu_wv, gpu_wv, gpu_skip;
  logic [ADDR_W-1:0] cpu_wa, gpu_wa, last_addr;
  logic [DATA_W-1:0] cpu_wd, gpu_wd;
  logic [2:0]        rd_q;
  logic [2:0]        elig, grant, read_gnt;
  rr_e               rr_ptr;
  slot_e             slot;
  logic              cpu_drain, gpu_drain;

  // Read handshake: the client holds read high; the cycle it is granted its
  // address goes to the RAM, and the next cycle ack pulses once with the data.
  // A pending or same-cycle write from the same client blocks its read so the
  // read always observes that client's own earlier write.
  assign elig[0] = cpu_mem_read  & ~rd_q[0] & ~cpu_wv & ~cpu_mem_write;
  assign elig[1] = gpu_mem_read  & ~rd_q[1] & ~gpu_wv & ~gpu_mem_write;
  assign elig[2] = scan_mem_read & ~rd_q[2];

  always_comb begin
    grant = 3'b000;
    case (rr_ptr)
      RR_GPU: begin
        if (elig[1])      grant = 3'b010;
        else if (elig[2]) grant = 3'b100;
        else if (elig[0]) grant = 3'b001;
      end
      RR_SCAN: begin
        if (elig[2])      grant = 3'b100;
        else if (elig[0]) grant = 3'b001;
        else if (elig[1]) grant = 3'b010;
      end
      default: begin
        if (elig[0])      grant = 3'b001;
        else if (elig[1]) grant = 3'b010;
        else if (elig[2]) grant = 3'b100;
      end
    endcase
  end

  // gpu_skip lets a GPU write that already lost one cycle to the CPU go first,
  // bounding every write's drain time to two cycles.
  always_comb begin
    slot = SLOT_IDLE;
    if (cpu_wv && !(gpu_wv && gpu_skip)) slot = SLOT_CPU_WR;
    else if (gpu_wv)                     slot = SLOT_GPU_WR;
    else if (grant != 3'b000)            slot = SLOT_READ;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = '0;
    mem_addr  = last_addr;
    read_gnt  = 3'b000;
    case (slot)
      SLOT_CPU_WR: begin
        mem_we    = 1'b1;
        mem_addr  = cpu_wa;
        mem_wdata = cpu_wd;
      end
      SLOT_GPU_WR: begin
        mem_we    = 1'b1;
        mem_addr  = gpu_wa;
        mem_wdata = gpu_wd;
      end
      SLOT_READ: begin
        read_gnt = grant;
        if (grant[0])      mem_addr = cpu_mem_read_addr;
        else if (grant[1]) mem_addr = gpu_mem_read_addr;
        else               mem_addr = scan_mem_read_addr;
      end
      default: ;
    endcase
  end

  assign cpu_drain = (slot == SLOT_CPU_WR);
  assign gpu_drain = (slot == SLOT_GPU_WR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_wv      <= 1'b0;
      cpu_wa      <= '0;
      cpu_wd      <= '0;
      gpu_wv      <= 1'b0;
      gpu_wa      <= '0;
      gpu_wd      <= '0;
      gpu_skip    <= 1'b0;
      rd_q        <= 3'b000;
      rr_ptr      <= RR_CPU;
      last_addr   <= '0;
      wr_overflow <= 1'b0;
    end else begin
      if (cpu_mem_write && (!cpu_wv || cpu_drain)) begin
        cpu_wv <= 1'b1;
        cpu_wa <= cpu_mem_write_addr;
        cpu_wd <= cpu_mem_write_data;
      end else if (cpu_drain) begin
        cpu_wv <= 1'b0;
      end
      if (gpu_mem_write && (!gpu_wv || gpu_drain)) begin
        gpu_wv <= 1'b1;
        gpu_wa <= gpu_mem_write_addr;
        gpu_wd <= gpu_mem_write_data;
      end else if (gpu_drain) begin
        gpu_wv <= 1'b0;
      end
      if ((cpu_mem_write && cpu_wv && !cpu_drain) ||
          (gpu_mem_write && gpu_wv && !gpu_drain))
        wr_overflow <= 1'b1;
      gpu_skip  <= gpu_wv && cpu_drain;
      rd_q      <= read_gnt;
      last_addr <= mem_addr;
      if (read_gnt[0])      rr_ptr <= RR_GPU;
      else if (read_gnt[1]) rr_ptr <= RR_SCAN;
      else if (read_gnt[2]) rr_ptr <= RR_CPU;
    end
  end

  assign cpu_mem_read_ack   = rd_q[0];
  assign gpu_mem_read_ack   = rd_q[1];
  assign scan_mem_read_ack  = rd_q[2];
  assign cpu_mem_read_data  = rd_q[0] ? mem_rdata : '0;
  assign gpu_mem_read_data  = rd_q[1] ? mem_rdata : '0;
  assign scan_mem_read_data = rd_q[2] ? mem_rdata : '0;

endmodule
